// File: rtl/note_synth_pwm.sv
// -----------------------------------------------------------------------------
// note_synth_pwm
//   Single-voice note synthesizer. A request picks one of seven notes (C4..B4),
//   plays it as a square wave for dur_ms milliseconds, follows it with a fixed
//   silent gap, then becomes ready again. The square wave is amplitude-scaled by
//   a free-running PWM carrier and emitted as a registered 1-bit audio stream.
//
// Parameters
//   PWM_BITS   : width of the PWM carrier counter (carrier = clk / 2^PWM_BITS), >= 3
//   GAP_CYCLES : silent cycles after each note, >= 1
//   MS_CYCLES  : clock cycles per millisecond, 1..131072
//   HALF_SHIFT : right shift applied to the half-period table (0 = true pitch);
//                nonzero values give scaled-down builds
//
// Ports
//   clk_100mhz : system clock
//   reset      : synchronous active-high reset
//   note_in    : note bitmask, bit0=C4 .. bit6=B4 (lowest set bit wins)
//   note_valid : play request, qualified by note_ready
//   dur_ms     : note duration in ms (0 = request discarded)
//   vol        : volume 0..7 (0 = silent)
//   note_ready : high in IDLE only
//   playing    : high while a tone is sounding
//   cur_note   : one-hot latched note, 0 when not playing
//   aud_pwm    : registered PWM audio output
//   aud_sd     : amplifier enable, high only while playing
// -----------------------------------------------------------------------------
module note_synth_pwm #(
   parameter int PWM_BITS   = 8,
   parameter int GAP_CYCLES = 1_000_000,
   parameter int MS_CYCLES  = 100_000,
   parameter int HALF_SHIFT = 0
) (
   input  logic       clk_100mhz,
   input  logic       reset,
   input  logic [6:0] note_in,
   input  logic       note_valid,
   input  logic [9:0] dur_ms,
   input  logic [2:0] vol,
   output logic       note_ready,
   output logic       playing,
   output logic [6:0] cur_note,
   output logic       aud_pwm,
   output logic       aud_sd
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t              state_reg, state_next;
   logic [6:0]          note_reg;
   logic [9:0]          dur_reg;
   logic [2:0]          vol_reg;
   logic [17:0]         tone_reg;
   logic                square_reg;
   logic [16:0]         ms_sub_reg;
   logic [9:0]          ms_cnt_reg;
   logic [GAP_W-1:0]    gap_reg;
   logic [PWM_BITS-1:0] pwm_reg;

   logic [6:0]          first_bit;
   logic [17:0]         half_full;
   logic [17:0]         half;
   logic [PWM_BITS-1:0] level;
   logic                accept;
   logic                tone_wrap;
   logic                ms_wrap;
   logic                play_done;
   logic                gap_done;

   // Priority select: keep only the lowest-index set bit of note_in.
   assign first_bit[0] = note_in[0];
   generate
      for (genvar gi = 1; gi < 7; gi++) begin : g_first
         assign first_bit[gi] = note_in[gi] & ~(|note_in[gi-1:0]);
      end
   endgenerate

   // Half-period (in clock cycles) of the latched note.
   always_comb begin
      half_full = 18'd191113;
      case (note_reg)
         7'b0000001: half_full = 18'd191113;  // C4
         7'b0000010: half_full = 18'd170265;  // D4
         7'b0000100: half_full = 18'd151685;  // E4
         7'b0001000: half_full = 18'd143172;  // F4
         7'b0010000: half_full = 18'd127551;  // G4
         7'b0100000: half_full = 18'd113636;  // A4
         7'b1000000: half_full = 18'd101239;  // B4
         default:    half_full = 18'd191113;
      endcase
   end

   assign half      = half_full >> HALF_SHIFT;
   assign level     = PWM_BITS'(vol_reg) << (PWM_BITS - 3);
   assign accept    = note_valid && (state_reg == IDLE) && (note_in != 7'd0) && (dur_ms != 10'd0);
   assign tone_wrap = (tone_reg == half - 18'd1);
   assign ms_wrap   = (ms_sub_reg == 17'(MS_CYCLES - 1));
   assign play_done = ms_wrap && (ms_cnt_reg == dur_reg - 10'd1);
   assign gap_done  = (gap_reg == GAP_W'(GAP_CYCLES - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept)    state_next = PLAY;
         PLAY:    if (play_done) state_next = GAP;
         GAP:     if (gap_done)  state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         state_reg  <= IDLE;
         note_reg   <= 7'd0;
         dur_reg    <= 10'd0;
         vol_reg    <= 3'd0;
         tone_reg   <= 18'd0;
         square_reg <= 1'b0;
         ms_sub_reg <= 17'd0;
         ms_cnt_reg <= 10'd0;
         gap_reg    <= '0;
         pwm_reg    <= '0;
         aud_pwm    <= 1'b0;
      end else begin
         state_reg <= state_next;
         pwm_reg   <= pwm_reg + PWM_BITS'(1);
         aud_pwm   <= (state_reg == PLAY) && square_reg && (pwm_reg < level);

         if (accept) begin
            note_reg   <= first_bit;
            dur_reg    <= dur_ms;
            vol_reg    <= vol;
            tone_reg   <= 18'd0;
            square_reg <= 1'b1;
            ms_sub_reg <= 17'd0;
            ms_cnt_reg <= 10'd0;
         end else if (state_reg == PLAY) begin
            if (tone_wrap) begin
               tone_reg   <= 18'd0;
               square_reg <= ~square_reg;
            end else begin
               tone_reg <= tone_reg + 18'd1;
            end
            if (ms_wrap) begin
               ms_sub_reg <= 17'd0;
               ms_cnt_reg <= ms_cnt_reg + 10'd1;
            end else begin
               ms_sub_reg <= ms_sub_reg + 17'd1;
            end
         end

         // Gap counter only runs in GAP; held at 0 elsewhere so GAP entry starts fresh.
         if (state_reg == GAP) gap_reg <= gap_reg + GAP_W'(1);
         else                  gap_reg <= '0;
      end
   end

   assign note_ready = (state_reg == IDLE);
   assign playing    = (state_reg == PLAY);
   assign aud_sd     = (state_reg == PLAY);
   assign cur_note   = (state_reg == PLAY) ? note_reg : 7'd0;

endmodule

// File: tb/tb_note_synth_pwm.sv
// -----------------------------------------------------------------------------
// tb_note_synth_pwm
//   Self-checking bench for note_synth_pwm, built with shortened timing
//   parameters. A cycle model predicts every output after each clock edge; the
//   prediction is queued when the stimulus is applied and popped and compared
//   once the DUT has clocked. A vector table drives single note requests and a
//   few hand-written sequences cover busy-time requests and mid-note reset.
// -----------------------------------------------------------------------------
module tb_note_synth_pwm;

   localparam int PWM_BITS   = 4;
   localparam int GAP_CYCLES = 50;
   localparam int MS_CYCLES  = 100;
   localparam int HALF_SHIFT = 10;

   logic       clk_100mhz = 1'b0;
   logic       reset      = 1'b1;
   logic [6:0] note_in    = 7'd0;
   logic       note_valid = 1'b0;
   logic [9:0] dur_ms     = 10'd0;
   logic [2:0] vol        = 3'd0;
   logic       note_ready;
   logic       playing;
   logic [6:0] cur_note;
   logic       aud_pwm;
   logic       aud_sd;

   always #5 clk_100mhz = ~clk_100mhz;

   note_synth_pwm #(
      .PWM_BITS   (PWM_BITS),
      .GAP_CYCLES (GAP_CYCLES),
      .MS_CYCLES  (MS_CYCLES),
      .HALF_SHIFT (HALF_SHIFT)
   ) dut (
      .clk_100mhz (clk_100mhz),
      .reset      (reset),
      .note_in    (note_in),
      .note_valid (note_valid),
      .dur_ms     (dur_ms),
      .vol        (vol),
      .note_ready (note_ready),
      .playing    (playing),
      .cur_note   (cur_note),
      .aud_pwm    (aud_pwm),
      .aud_sd     (aud_sd)
   );

   typedef struct packed {
      logic       ready;
      logic       play;
      logic       sd;
      logic       pwm;
      logic [6:0] cur;
   } obs_t;

   typedef struct {
      logic [6:0] note;
      int         dur;
      int         vl;
      logic       acc;
      logic [6:0] exp_cur;
      logic       duty_chk;
   } vec_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Cycle model state (0 = IDLE, 1 = PLAY, 2 = GAP).
   int         m_state = 0;
   int         m_j     = 0;
   int         m_dur   = 0;
   int         m_vol   = 0;
   int         m_half  = 1;
   int         m_pwm   = 0;
   logic [6:0] m_note  = 7'd0;
   logic       m_aud   = 1'b0;

   function automatic logic [6:0] lowest(input logic [6:0] n);
      for (int i = 0; i < 7; i++) begin
         if (n[i]) return 7'(1 << i);
      end
      return 7'd0;
   endfunction

   function automatic int half_of(input logic [6:0] oh);
      case (oh)
         7'h01:   return 191113;
         7'h02:   return 170265;
         7'h04:   return 151685;
         7'h08:   return 143172;
         7'h10:   return 127551;
         7'h20:   return 113636;
         7'h40:   return 101239;
         default: return 1024;
      endcase
   endfunction

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_step();
      obs_t e;
      if (reset) begin
         m_state = 0;
         m_j     = 0;
         m_pwm   = 0;
         m_aud   = 1'b0;
      end else begin
         // Square is high for the first half-period of PLAY and alternates after.
         m_aud = (m_state == 1) && (((m_j / m_half) % 2) == 0) &&
                 (m_pwm < (m_vol << (PWM_BITS - 3)));
         m_pwm = (m_pwm + 1) % (1 << PWM_BITS);
         case (m_state)
            0: if (note_valid && note_in != 7'd0 && dur_ms != 10'd0) begin
                  m_state = 1;
                  m_j     = 0;
                  m_note  = lowest(note_in);
                  m_half  = half_of(m_note) >> HALF_SHIFT;
                  m_dur   = int'(dur_ms);
                  m_vol   = int'(vol);
               end
            1: if (m_j == m_dur * MS_CYCLES - 1) begin
                  m_state = 2;
                  m_j     = 0;
               end else begin
                  m_j++;
               end
            default: if (m_j == GAP_CYCLES - 1) begin
                  m_state = 0;
                  m_j     = 0;
               end else begin
                  m_j++;
               end
         endcase
      end
      e.ready = (m_state == 0);
      e.play  = (m_state == 1);
      e.sd    = (m_state == 1);
      e.pwm   = m_aud;
      e.cur   = (m_state == 1) ? m_note : 7'd0;
      exp_q.push_back(e);
   endtask

   // One clock: queue the prediction, clock the DUT, compare 1 ns after the edge.
   task automatic tick();
      obs_t e;
      obs_t a;
      model_step();
      @(posedge clk_100mhz);
      #1;
      e       = exp_q.pop_front();
      a.ready = note_ready;
      a.play  = playing;
      a.sd    = aud_sd;
      a.pwm   = aud_pwm;
      a.cur   = cur_note;
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL outputs t=%0t got ready=%b playing=%b sd=%b pwm=%b cur=%h want ready=%b playing=%b sd=%b pwm=%b cur=%h",
                  $time, a.ready, a.play, a.sd, a.pwm, a.cur, e.ready, e.play, e.sd, e.pwm, e.cur);
      end
   endtask

   task automatic run_until_idle();
      for (int n = 0; n < 3000 && m_state != 0; n++) tick();
      for (int n = 0; n < 3; n++) tick();
   endtask

   task automatic request(input logic [6:0] n, input int d, input int v);
      note_in    = n;
      dur_ms     = 10'(d);
      vol        = 3'(v);
      note_valid = 1'b1;
      tick();
      note_valid = 1'b0;
   endtask

   vec_t vecs[7];

   initial begin
      int duty;
      vecs[0] = '{note: 7'h20, dur: 2, vl: 7, acc: 1'b1, exp_cur: 7'h20, duty_chk: 1'b0};
      vecs[1] = '{note: 7'h0C, dur: 1, vl: 4, acc: 1'b1, exp_cur: 7'h04, duty_chk: 1'b1};
      vecs[2] = '{note: 7'h40, dur: 1, vl: 0, acc: 1'b1, exp_cur: 7'h40, duty_chk: 1'b0};
      vecs[3] = '{note: 7'h00, dur: 3, vl: 7, acc: 1'b0, exp_cur: 7'h00, duty_chk: 1'b0};
      vecs[4] = '{note: 7'h10, dur: 0, vl: 5, acc: 1'b0, exp_cur: 7'h00, duty_chk: 1'b0};
      vecs[5] = '{note: 7'h7F, dur: 1, vl: 2, acc: 1'b1, exp_cur: 7'h01, duty_chk: 1'b0};
      vecs[6] = '{note: 7'h18, dur: 3, vl: 6, acc: 1'b1, exp_cur: 7'h08, duty_chk: 1'b0};

      // Reset state.
      for (int n = 0; n < 3; n++) tick();
      reset = 1'b0;
      for (int n = 0; n < 5; n++) tick();

      for (int i = 0; i < 7; i++) begin
         request(vecs[i].note, vecs[i].dur, vecs[i].vl);
         checks++;
         if (playing !== vecs[i].acc || cur_note !== vecs[i].exp_cur) begin
            errors++;
            $display("FAIL handshake vec=%0d got playing=%b cur=%h want playing=%b cur=%h",
                     i, playing, cur_note, vecs[i].acc, vecs[i].exp_cur);
         end
         if (vecs[i].duty_chk) begin
            // aud_pwm lags one cycle; 16 carrier cycles with square high at half volume.
            duty = 0;
            tick();
            for (int n = 0; n < 16; n++) begin
               tick();
               duty += int'(aud_pwm);
            end
            checks++;
            if (duty != 8) begin
               errors++;
               $display("FAIL duty vol=4 got %0d high of 16 want 8", duty);
            end
         end
         run_until_idle();
      end

      // Requests during PLAY are ignored.
      request(7'h02, 2, 3);
      for (int n = 0; n < 20; n++) tick();
      note_in    = 7'h40;
      dur_ms     = 10'd5;
      vol        = 3'd7;
      note_valid = 1'b1;
      for (int n = 0; n < 20; n++) tick();
      checks++;
      if (cur_note !== 7'h02) begin
         errors++;
         $display("FAIL busy_ignore got cur=%h want 02", cur_note);
      end
      note_valid = 1'b0;
      run_until_idle();

      // Reset partway into PLAY.
      request(7'h20, 2, 7);
      for (int n = 0; n < 50; n++) tick();
      reset = 1'b1;
      tick();
      checks++;
      if (playing !== 1'b0 || aud_sd !== 1'b0 || aud_pwm !== 1'b0 || cur_note !== 7'd0) begin
         errors++;
         $display("FAIL mid_reset got playing=%b sd=%b pwm=%b cur=%h want 0 0 0 00",
                  playing, aud_sd, aud_pwm, cur_note);
      end
      tick();
      reset = 1'b0;
      for (int n = 0; n < 4; n++) tick();
      checks++;
      if (note_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got %b want 1", note_ready);
      end

      // A fresh note plays normally after the reset.
      request(7'h08, 1, 4);
      run_until_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
